// File: rtl/ahb3lite_slave_mem.sv
// AHB-Lite SRAM slave with word-organised storage, programmable wait states and two-cycle ERROR response.
// Latency: WAIT_STATES low HREADYOUT cycles per OKAY data phase, then one completing cycle; errors take two cycles.
// Backpressure: HREADYOUT low stalls the bus; AHB3LITE_MEM_RO_REGION_EN makes the low RO_WORDS words read-only.
module ahb3lite_slave_mem #(
    parameter int MEM_WORDS   = 256,
    parameter int WAIT_STATES = 1,
    parameter int RO_WORDS    = 16
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HRESP,
    output logic        HREADYOUT
);

    localparam int          AW         = $clog2(MEM_WORDS);
    localparam logic [31:0] BYTE_LIMIT = 32'(MEM_WORDS * 4);
    localparam logic [3:0]  WS         = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t         state;
    logic [3:0]     wcnt;
    logic [AW-1:0]  idx_q;
    logic [1:0]     lo_q;
    logic [1:0]     size_q;
    logic           write_q;
    logic           ready_q;
    logic           resp_q;
    logic [31:0]    rdata_q;

    logic [31:0]    mem [MEM_WORDS];

    logic           accept;
    logic           bad_range;
    logic           bad_size;
    logic           bad_align;
    logic           bad_ro;
    logic           bad;
    logic [AW-1:0]  idx_in;
    logic           done;
    logic           open;
    logic           wr_en;
    logic [3:0]     lane;
    logic [31:0]    bitmask;
    logic [31:0]    wr_word;
    logic [31:0]    rd_word;

    // Burst type, protection and the slot-select address bits carry no meaning for this slave.
    logic           unused_inputs;
    assign unused_inputs = ^{HBURST, HPROT, HADDR[31:30], HTRANS[0]};

    // Address-phase qualification and error classification.
    assign accept    = HSEL & HREADY & HTRANS[1];
    assign bad_range = {2'b00, HADDR[29:0]} >= BYTE_LIMIT;
    assign bad_size  = HSIZE > 3'b010;
    assign bad_align = ((HSIZE == 3'b001) && HADDR[0]) ||
                       ((HSIZE == 3'b010) && (HADDR[1:0] != 2'b00));
`ifdef AHB3LITE_MEM_RO_REGION_EN
    assign bad_ro    = HWRITE && ({4'b0000, HADDR[29:2]} < 32'(RO_WORDS));
`else
    localparam int ro_words_unused = RO_WORDS;
    assign bad_ro    = 1'b0;
`endif
    assign bad       = bad_range | bad_size | bad_align | bad_ro;
    assign idx_in    = HADDR[AW+1:2];

    // A data phase completes in DATA once the wait counter has drained; a new
    // address phase may be taken whenever the slave is presenting HREADYOUT=1.
    assign done  = (state == ST_DATA) && (wcnt == 4'd0);
    assign open  = (state == ST_IDLE) || (state == ST_ERR2) || done;
    assign wr_en = done && write_q && !HRESET;

    // Byte-lane enables for the stored write, little-endian lane = address[1:0].
    always_comb begin
        lane = 4'b1111;
        case (size_q)
            2'b00:   lane = 4'b0001 << lo_q;
            2'b01:   lane = lo_q[1] ? 4'b1100 : 4'b0011;
            default: lane = 4'b1111;
        endcase
    end

    assign bitmask = {{8{lane[3]}}, {8{lane[2]}}, {8{lane[1]}}, {8{lane[0]}}};
    assign wr_word = (mem[idx_q] & ~bitmask) | (HWDATA & bitmask);

    // A read accepted on the very edge a write to the same word lands must see
    // the merged word, so forward it around the array.
    assign rd_word = (wr_en && (idx_q == idx_in)) ? wr_word : mem[idx_in];

    // Storage array: not reset, updated only at the completing edge of an OKAY write.
    always_ff @(posedge HCLK) begin
        if (wr_en) begin
            mem[idx_q] <= wr_word;
        end
    end

    // Transfer FSM with registered HREADYOUT/HRESP/HRDATA.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state   <= ST_IDLE;
            wcnt    <= 4'd0;
            ready_q <= 1'b1;
            resp_q  <= 1'b0;
            rdata_q <= 32'h0;
            idx_q   <= '0;
            lo_q    <= 2'b00;
            size_q  <= 2'b00;
            write_q <= 1'b0;
        end else if (open) begin
            if (accept && bad) begin
                state   <= ST_ERR1;
                wcnt    <= 4'd0;
                ready_q <= 1'b0;
                resp_q  <= 1'b1;
                rdata_q <= 32'h0;
            end else if (accept) begin
                state   <= ST_DATA;
                wcnt    <= WS;
                ready_q <= (WS == 4'd0);
                resp_q  <= 1'b0;
                rdata_q <= ((WS == 4'd0) && !HWRITE) ? rd_word : 32'h0;
                idx_q   <= idx_in;
                lo_q    <= HADDR[1:0];
                size_q  <= HSIZE[1:0];
                write_q <= HWRITE;
            end else begin
                state   <= ST_IDLE;
                wcnt    <= 4'd0;
                ready_q <= 1'b1;
                resp_q  <= 1'b0;
                rdata_q <= 32'h0;
            end
        end else if (state == ST_ERR1) begin
            state   <= ST_ERR2;
            ready_q <= 1'b1;
            resp_q  <= 1'b1;
            rdata_q <= 32'h0;
        end else begin
            // DATA with wait cycles outstanding: no write can land meanwhile,
            // so the array read is already final for the completing cycle.
            wcnt    <= wcnt - 4'd1;
            ready_q <= (wcnt == 4'd1);
            resp_q  <= 1'b0;
            rdata_q <= ((wcnt == 4'd1) && !write_q) ? mem[idx_q] : 32'h0;
        end
    end

    assign HREADYOUT = ready_q;
    assign HRESP     = resp_q;
    assign HRDATA    = rdata_q;

endmodule
